// File: rtl/ace_ccu_snoop_sched.sv
// Round-robin scheduler sharing the single CCU snoop-request channel among
// NoMst ACE masters. Issues one request at a time, bounds outstanding snoops
// to MaxTrans and routes in-order completions back to the originating master.
// Optional feature macro: ACE_CCU_SCHED_LINE_CONFLICT_EN -- when defined, a
// requester whose cache line matches an outstanding snoop is skipped.
module ace_ccu_snoop_sched #(
   parameter int unsigned NoMst     = 4,
   parameter int unsigned AddrWidth = 64,
   parameter int unsigned LineBytes = 64,
   parameter int unsigned MaxTrans  = 4,
   localparam int unsigned IdxW     = (NoMst > 1) ? $clog2(NoMst) : 1
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic [NoMst-1:0]           req_valid_i,
   output logic [NoMst-1:0]           req_ready_o,
   input  logic [NoMst-1:0]           req_write_i,
   input  logic [NoMst*AddrWidth-1:0] req_addr_i,
   output logic                       snp_valid_o,
   input  logic                       snp_ready_i,
   output logic                       snp_write_o,
   output logic [AddrWidth-1:0]       snp_addr_o,
   output logic [IdxW-1:0]            snp_mst_o,
   input  logic                       snp_done_i,
   output logic [NoMst-1:0]           done_o,
   output logic                       busy_o
);

   localparam int unsigned PtrW = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
   localparam int unsigned CntW = $clog2(MaxTrans + 1);

   typedef enum logic {IDLE, ISSUE} state_e;

   state_e           state;
   logic [IdxW-1:0]  rr_ptr;
   logic [CntW-1:0]  count;
   logic [CntW-1:0]  count_nxt;
   logic [PtrW-1:0]  wr_ptr;
   logic [PtrW-1:0]  rd_ptr;
   logic [IdxW-1:0]  fifo_idx [MaxTrans];
   logic [NoMst-1:0] eligible;
   logic [NoMst-1:0] done_nxt;
   logic             sel_vld;
   logic [IdxW-1:0]  sel_idx;
   int unsigned      cand;
   logic             push;
   logic             pop;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(MaxTrans - 1)) ? '0 : p + PtrW'(1);
   endfunction

   // Handshake pushes the granted index; a completion pops the oldest entry.
   assign push = (state == ISSUE) && snp_ready_i;
   assign pop  = snp_done_i && (count != '0);

`ifdef ACE_CCU_SCHED_LINE_CONFLICT_EN
   localparam int unsigned LineShift = $clog2(LineBytes);
   localparam int unsigned LineW     = AddrWidth - LineShift;

   logic [LineW-1:0]    fifo_line [MaxTrans];
   logic [MaxTrans-1:0] slot_vld;

   // Mask requesters whose cache line matches any outstanding snoop.
   always_comb begin
      eligible = req_valid_i;
      for (int unsigned m = 0; m < NoMst; m++) begin
         for (int unsigned s = 0; s < MaxTrans; s++) begin
            if (slot_vld[s] && (req_addr_i[m*AddrWidth+LineShift +: LineW] == fifo_line[s])) begin
               eligible[m] = 1'b0;
            end
         end
      end
   end

   // Line addresses of outstanding entries; a pop and a push to the same slot leave it valid.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         slot_vld <= '0;
         for (int unsigned s = 0; s < MaxTrans; s++) begin
            fifo_line[s] <= '0;
         end
      end else begin
         if (pop) begin
            slot_vld[rd_ptr] <= 1'b0;
         end
         if (push) begin
            slot_vld[wr_ptr]  <= 1'b1;
            fifo_line[wr_ptr] <= snp_addr_o[AddrWidth-1:LineShift];
         end
      end
   end
`else
   // Without conflict tracking every valid requester is eligible.
   assign eligible = req_valid_i;
`endif

   // First eligible requester at or after the round-robin pointer, wrapping.
   always_comb begin
      sel_vld = 1'b0;
      sel_idx = '0;
      cand    = 0;
      for (int unsigned k = 0; k < NoMst; k++) begin
         cand = (32'(rr_ptr) + k) % NoMst;
         if (!sel_vld && eligible[cand]) begin
            sel_vld = 1'b1;
            sel_idx = IdxW'(cand);
         end
      end
   end

   // Outstanding count after this cycle's push/pop.
   always_comb begin
      count_nxt = count;
      if (push && !pop) begin
         count_nxt = count + CntW'(1);
      end else if (pop && !push) begin
         count_nxt = count - CntW'(1);
      end
   end

   // Accept pulse to the granted master, combinational on the CCU handshake.
   always_comb begin
      req_ready_o = '0;
      for (int unsigned i = 0; i < NoMst; i++) begin
         req_ready_o[i] = push && (snp_mst_o == IdxW'(i));
      end
   end

   // One-hot completion target taken from the oldest FIFO entry.
   always_comb begin
      done_nxt = '0;
      for (int unsigned i = 0; i < NoMst; i++) begin
         done_nxt[i] = pop && (fifo_idx[rd_ptr] == IdxW'(i));
      end
   end

   // Issue FSM, completion FIFO and registered outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         count       <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         snp_valid_o <= 1'b0;
         snp_write_o <= 1'b0;
         snp_addr_o  <= '0;
         snp_mst_o   <= '0;
         done_o      <= '0;
         busy_o      <= 1'b0;
         for (int unsigned s = 0; s < MaxTrans; s++) begin
            fifo_idx[s] <= '0;
         end
      end else begin
         done_o <= done_nxt;
         count  <= count_nxt;
         busy_o <= (count_nxt != '0);
         if (push) begin
            fifo_idx[wr_ptr] <= snp_mst_o;
            wr_ptr           <= ptr_inc(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         case (state)
            IDLE: begin
               // Full check uses the registered count: a same-cycle pop does not help.
               if (sel_vld && (count < CntW'(MaxTrans))) begin
                  snp_valid_o <= 1'b1;
                  snp_addr_o  <= req_addr_i[32'(sel_idx)*AddrWidth +: AddrWidth];
                  snp_write_o <= req_write_i[sel_idx];
                  snp_mst_o   <= sel_idx;
                  state       <= ISSUE;
               end
            end
            ISSUE: begin
               if (snp_ready_i) begin
                  snp_valid_o <= 1'b0;
                  rr_ptr      <= IdxW'((32'(snp_mst_o) + 32'd1) % NoMst);
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifndef SYNTHESIS
   // Completions with nothing outstanding and non power-of-two line sizes are errors.
   always @(posedge clk_i) begin
      if (rst_ni) begin
         assert (!snp_done_i || (count != '0));
         assert ((LineBytes & (LineBytes - 1)) == 0);
      end
   end
`endif

endmodule

// File: tb/tb_ace_ccu_snoop_sched.sv
// Self-checking bench for ace_ccu_snoop_sched: directed scenarios followed by
// randomized traffic, all checked against a transaction-level queue model.
module tb_ace_ccu_snoop_sched;

   localparam int N  = 4;
   localparam int AW = 64;
   localparam int MT = 4;

   logic            clk_i = 1'b0;
   logic            rst_ni = 1'b1;
   logic [N-1:0]    req_valid_i = '0;
   logic [N-1:0]    req_ready_o;
   logic [N-1:0]    req_write_i = '0;
   logic [N*AW-1:0] req_addr_i;
   logic            snp_valid_o;
   logic            snp_ready_i = 1'b0;
   logic            snp_write_o;
   logic [AW-1:0]   snp_addr_o;
   logic [1:0]      snp_mst_o;
   logic            snp_done_i = 1'b0;
   logic [N-1:0]    done_o;
   logic            busy_o;

   logic [AW-1:0]   req_addr [N];

   assign req_addr_i = {req_addr[3], req_addr[2], req_addr[1], req_addr[0]};

   always #5 clk_i = ~clk_i;

   ace_ccu_snoop_sched #(
      .NoMst(N), .AddrWidth(AW), .LineBytes(64), .MaxTrans(MT)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_write_i(req_write_i), .req_addr_i(req_addr_i),
      .snp_valid_o(snp_valid_o), .snp_ready_i(snp_ready_i),
      .snp_write_o(snp_write_o), .snp_addr_o(snp_addr_o), .snp_mst_o(snp_mst_o),
      .snp_done_i(snp_done_i), .done_o(done_o), .busy_o(busy_o)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: one registered request slot plus a queue of outstanding grants.
   bit          m_issue = 0;
   int          m_mst = 0;
   logic [63:0] m_addr = '0;
   bit          m_write = 0;
   int          m_ptr = 0;
   int          q_mst[$];
`ifdef ACE_CCU_SCHED_LINE_CONFLICT_EN
   logic [63:0] q_line[$];
`endif
   logic [3:0]  m_done = '0;
   bit          m_busy = 0;

   bit          keep_req = 0;
   int          grants[$];
   int          grant_cyc[$];
   int          cyc = 0;
   logic [3:0]  last_rr = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Advance the model across one clock edge using the inputs held this cycle.
   task automatic model_edge(output logic [3:0] acc);
      bit push;
      bit pop;
      push = m_issue && snp_ready_i;
      pop  = snp_done_i && (q_mst.size() > 0);
      acc  = push ? 4'(1 << m_mst) : 4'b0;
      m_done = pop ? 4'(1 << q_mst[0]) : 4'b0;
      if (!m_issue) begin
         if (q_mst.size() < MT) begin
            for (int k = 0; k < N; k++) begin
               int c;
               bit skip;
               c = (m_ptr + k) % N;
               skip = 0;
`ifdef ACE_CCU_SCHED_LINE_CONFLICT_EN
               foreach (q_line[j]) if (q_line[j] == (req_addr[c] >> 6)) skip = 1;
`endif
               if (req_valid_i[c] && !skip) begin
                  m_issue = 1;
                  m_mst   = c;
                  m_addr  = req_addr[c];
                  m_write = req_write_i[c];
                  break;
               end
            end
         end
      end else if (push) begin
         m_issue = 0;
         m_ptr   = (m_mst + 1) % N;
      end
      if (pop) begin
         void'(q_mst.pop_front());
`ifdef ACE_CCU_SCHED_LINE_CONFLICT_EN
         void'(q_line.pop_front());
`endif
      end
      if (push) begin
         q_mst.push_back(m_mst);
`ifdef ACE_CCU_SCHED_LINE_CONFLICT_EN
         q_line.push_back(m_addr >> 6);
`endif
         grants.push_back(m_mst);
         grant_cyc.push_back(cyc);
      end
      m_busy = (q_mst.size() != 0);
   endtask

   // One clock cycle, entered and left at the falling edge with inputs already driven.
   task automatic cycle();
      logic [3:0] exp_rr;
      logic [3:0] acc;
      #1;
      exp_rr  = (m_issue && snp_ready_i) ? 4'(1 << m_mst) : 4'b0;
      last_rr = req_ready_o;
      chk("req_ready", 64'(req_ready_o), 64'(exp_rr));
      @(posedge clk_i);
      model_edge(acc);
      cyc++;
      @(negedge clk_i);
      chk("snp_valid", 64'(snp_valid_o), 64'(m_issue));
      chk("busy", 64'(busy_o), 64'(m_busy));
      chk("done", 64'(done_o), 64'(m_done));
      if (m_issue) begin
         chk("snp_addr", snp_addr_o, m_addr);
         chk("snp_write", 64'(snp_write_o), 64'(m_write));
         chk("snp_mst", 64'(snp_mst_o), 64'(m_mst));
      end
      for (int m = 0; m < N; m++) begin
         if (acc[m] && !keep_req) req_valid_i[m] = 1'b0;
      end
   endtask

   // Asynchronous reset: outputs must clear immediately, then release at a falling edge.
   task automatic do_reset();
      rst_ni      = 1'b0;
      req_valid_i = '0;
      req_write_i = '0;
      snp_ready_i = 1'b0;
      snp_done_i  = 1'b0;
      #1;
      chk("rst_snp_valid", 64'(snp_valid_o), 64'd0);
      chk("rst_req_ready", 64'(req_ready_o), 64'd0);
      chk("rst_done", 64'(done_o), 64'd0);
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_snp_addr", snp_addr_o, 64'd0);
      chk("rst_snp_write", 64'(snp_write_o), 64'd0);
      chk("rst_snp_mst", 64'(snp_mst_o), 64'd0);
      m_issue = 0; m_mst = 0; m_addr = '0; m_write = 0; m_ptr = 0;
      m_done = '0; m_busy = 0;
      q_mst.delete();
`ifdef ACE_CCU_SCHED_LINE_CONFLICT_EN
      q_line.delete();
`endif
      grants.delete();
      grant_cyc.delete();
      cyc = 0;
      @(negedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   task automatic rand_cycle();
      for (int m = 0; m < N; m++) begin
         if (!req_valid_i[m] && ($urandom_range(99) < 40)) begin
            req_valid_i[m] = 1'b1;
            req_addr[m]    = 64'h1_0000 + 64'($urandom_range(0, 7)) * 64'd64 + 64'($urandom_range(0, 63));
            req_write_i[m] = 1'($urandom_range(0, 1));
         end
      end
      snp_ready_i = ($urandom_range(99) < 70);
      snp_done_i  = (q_mst.size() > 0) && ($urandom_range(99) < 30);
      cycle();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
      $fatal(1);
   end

   initial begin
      int exp_ord [6];
      int exp_c1;
      int exp_c2;
      exp_ord = '{0, 1, 2, 3, 0, 1};
      for (int m = 0; m < N; m++) req_addr[m] = '0;
      @(negedge clk_i);
      do_reset();

      // Single master, write request, ready tied high.
      req_valid_i = 4'b0001; req_addr[0] = 64'h1000; req_write_i = 4'b0001; snp_ready_i = 1'b1;
      cycle();
      chk("t1_valid", 64'(snp_valid_o), 64'd1);
      chk("t1_addr", snp_addr_o, 64'h1000);
      chk("t1_write", 64'(snp_write_o), 64'd1);
      chk("t1_mst", 64'(snp_mst_o), 64'd0);
      cycle();
      chk("t1_ready_pulse", 64'(last_rr), 64'b0001);
      chk("t1_busy", 64'(busy_o), 64'd1);
      chk("t1_valid_drop", 64'(snp_valid_o), 64'd0);
      cycle();
      chk("t1_no_regrant", 64'(snp_valid_o), 64'd0);
      snp_done_i = 1'b1;
      cycle();
      snp_done_i = 1'b0;
      chk("t1_done", 64'(done_o), 64'b0001);
      chk("t1_busy_clear", 64'(busy_o), 64'd0);
      cycle();
      chk("t1_done_single", 64'(done_o), 64'd0);

      // All masters request continuously, one completion per grant.
      do_reset();
      keep_req = 1; req_valid_i = 4'hF; snp_ready_i = 1'b1;
      for (int m = 0; m < N; m++) req_addr[m] = 64'h2000 + 64'(m) * 64'h40;
      for (int i = 0; i < 12; i++) begin
         snp_done_i = (q_mst.size() > 0);
         cycle();
      end
      snp_done_i = 1'b0;
      chk("t2_ngrant", 64'(grants.size()), 64'd6);
      for (int i = 0; i < 6; i++) begin
         if (i < grants.size()) chk("t2_order", 64'(grants[i]), 64'(exp_ord[i]));
      end
      for (int i = 1; i < grants.size(); i++) begin
         chk("t2_spacing", 64'(grant_cyc[i] - grant_cyc[i-1]), 64'd2);
      end

      // Outstanding limit, then full-queue push and pop in the same cycle.
      do_reset();
      keep_req = 1; req_valid_i = 4'hF; snp_ready_i = 1'b1;
      repeat (10) cycle();
      chk("t3_ngrant", 64'(grants.size()), 64'd4);
      chk("t3_stall", 64'(snp_valid_o), 64'd0);
      chk("t3_busy", 64'(busy_o), 64'd1);
      snp_done_i = 1'b1;
      cycle();
      snp_done_i = 1'b0;
      chk("t3_done_oldest", 64'(done_o), 64'b0001);
      chk("t3_no_same_cycle_sel", 64'(snp_valid_o), 64'd0);
      cycle();
      chk("t3_fifth_valid", 64'(snp_valid_o), 64'd1);
      chk("t3_fifth_mst", 64'(snp_mst_o), 64'd0);
      cycle();
      chk("t3_ngrant5", 64'(grants.size()), 64'd5);
      snp_ready_i = 1'b0; snp_done_i = 1'b1;
      cycle();
      chk("t5_pop", 64'(done_o), 64'b0010);
      snp_done_i = 1'b0;
      cycle();
      chk("t5_sel", 64'(snp_valid_o), 64'd1);
      chk("t5_sel_mst", 64'(snp_mst_o), 64'd1);
      snp_ready_i = 1'b1; snp_done_i = 1'b1;
      cycle();
      chk("t5_hs_ready", 64'(last_rr), 64'b0010);
      chk("t5_done_oldest", 64'(done_o), 64'b0100);
      chk("t5_busy", 64'(busy_o), 64'd1);
      keep_req = 0; req_valid_i = '0; snp_ready_i = 1'b0;
      cycle();
      chk("t5_drain0", 64'(done_o), 64'b1000);
      cycle();
      chk("t5_drain1", 64'(done_o), 64'b0001);
      cycle();
      chk("t5_drain2", 64'(done_o), 64'b0010);
      chk("t5_drain_busy", 64'(busy_o), 64'd0);
      snp_done_i = 1'b0;

      // CCU backpressure keeps the request stable.
      do_reset();
      req_valid_i = 4'b0100; req_addr[2] = 64'hABC0; snp_ready_i = 1'b0;
      cycle();
      chk("t4_valid", 64'(snp_valid_o), 64'd1);
      chk("t4_mst", 64'(snp_mst_o), 64'd2);
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("t4_hold_valid", 64'(snp_valid_o), 64'd1);
         chk("t4_hold_addr", snp_addr_o, 64'hABC0);
         chk("t4_hold_mst", 64'(snp_mst_o), 64'd2);
         chk("t4_no_ready", 64'(last_rr), 64'd0);
      end
      snp_ready_i = 1'b1;
      cycle();
      chk("t4_ready", 64'(last_rr), 64'b0100);
      chk("t4_valid_drop", 64'(snp_valid_o), 64'd0);
      snp_ready_i = 1'b0; snp_done_i = 1'b1;
      cycle();
      snp_done_i = 1'b0;
      chk("t4_done", 64'(done_o), 64'b0100);

      // Same-line requester versus a different-line requester.
      do_reset();
      snp_ready_i = 1'b1;
      req_valid_i = 4'b0001; req_addr[0] = 64'h1040;
      cycle();
      cycle();
      req_valid_i[1] = 1'b1; req_addr[1] = 64'h1078;
      req_valid_i[2] = 1'b1; req_addr[2] = 64'h2000;
      repeat (4) cycle();
      snp_done_i = 1'b1;
      cycle();
      snp_done_i = 1'b0;
      repeat (3) cycle();
`ifdef ACE_CCU_SCHED_LINE_CONFLICT_EN
      exp_c1 = 2; exp_c2 = 1;
`else
      exp_c1 = 1; exp_c2 = 2;
`endif
      chk("t6_ngrant", 64'(grants.size()), 64'd3);
      if (grants.size() == 3) begin
         chk("t6_first", 64'(grants[0]), 64'd0);
         chk("t6_second", 64'(grants[1]), 64'(exp_c1));
         chk("t6_third", 64'(grants[2]), 64'(exp_c2));
      end
      snp_ready_i = 1'b0;
      while (q_mst.size() > 0) begin
         snp_done_i = 1'b1;
         cycle();
      end
      snp_done_i = 1'b0;

      // Randomized traffic with a reset in the middle of operation.
      do_reset();
      repeat (1500) rand_cycle();
      #3;
      do_reset();
      repeat (1000) rand_cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
